// File: rtl/halt_resume_ctrl_pkg.sv
// halt_ctrl_pkg: shared types and constants for the halt/resume protocol.
// Shared with the decode-stage halt detector.
package halt_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      HALTED,
      RESUME
   } halt_state_t;

   localparam int XLEN = 32;
   localparam int INSN_BYTES = 4;
   localparam logic [31:0] HALT_INSTRUCTION = 32'hFFFF_FFFF;

endpackage

// File: rtl/halt_resume_ctrl_if.sv
// halt_resume_ctrl_if: decode/IF-side signals of the halt/resume controller.
// master = environment (detector, debugger, IF stage), slave = controller.
interface halt_resume_ctrl_if
   import halt_ctrl_pkg::*;
#(
   parameter int COUNT_W = 16
);

   logic               Halt;
   logic [XLEN-1:0]    Halt_PC;
   logic               Resume_Req;
   logic               Resume_Use_PC;
   logic [XLEN-1:0]    Resume_PC;
   logic               Resume_Ack;
   logic               Stall_Fetch;
   logic               Flush_Younger;
   logic               Halted;
   logic [XLEN-1:0]    Halted_PC;
   logic               PC_Load;
   logic [XLEN-1:0]    PC_Load_Value;
   logic [COUNT_W-1:0] Halt_Count;
   logic               Timeout;

   modport master (
      output Halt, Halt_PC, Resume_Req, Resume_Use_PC, Resume_PC,
      input  Resume_Ack, Stall_Fetch, Flush_Younger, Halted,
      input  Halted_PC, PC_Load, PC_Load_Value, Halt_Count, Timeout
   );

   modport slave (
      input  Halt, Halt_PC, Resume_Req, Resume_Use_PC, Resume_PC,
      output Resume_Ack, Stall_Fetch, Flush_Younger, Halted,
      output Halted_PC, PC_Load, PC_Load_Value, Halt_Count, Timeout
   );

endinterface

// File: rtl/halt_cycle_counter.sv
// halt_cycle_counter: loadable down-counter with zero flag.
// Holds at zero; load has priority over decrement.
module halt_cycle_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/halt_resume_ctrl.sv
// halt_resume_ctrl: stall/squash/drain on HALT, hold halted, resume on request.
// Optional watchdog auto-resume enabled by `define HALT_AUTO_RESUME_EN.
module halt_resume_ctrl
   import halt_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES       = 3,
   parameter int COUNT_W            = 16,
   parameter int AUTO_RESUME_CYCLES = 1024
) (
   input logic               clk,
   input logic               reset_n,
   halt_resume_ctrl_if.slave bus
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   if (DRAIN_CYCLES < 1 || AUTO_RESUME_CYCLES < 1) begin : g_bad_param
      $error("halt_resume_ctrl: DRAIN_CYCLES and AUTO_RESUME_CYCLES must be >= 1");
   end

   halt_state_t        state_q;
   halt_state_t        state_d;
   logic               halt_take;
   logic               drain_zero;
   logic               wd_fire;
   logic               first_q;
   logic [XLEN-1:0]    hpc_q;
   logic [XLEN-1:0]    tgt_q;
   logic [COUNT_W-1:0] hcnt_q;

   assign halt_take = (state_q == RUN) && bus.Halt;

   halt_cycle_counter #(.W(DW)) u_drain (
      .clk      (clk),
      .rst_n    (reset_n),
      .load     (halt_take),
      .load_val (DW'(DRAIN_CYCLES - 1)),
      .dec      (state_q == DRAIN),
      .zero     (drain_zero)
   );

`ifdef HALT_AUTO_RESUME_EN
   localparam int AW = (AUTO_RESUME_CYCLES > 1) ? $clog2(AUTO_RESUME_CYCLES) : 1;

   logic wd_zero;
   logic tmo_q;

   // Reloaded on the DRAIN->HALTED edge so the first HALTED cycle counts as 0
   halt_cycle_counter #(.W(AW)) u_wdog (
      .clk      (clk),
      .rst_n    (reset_n),
      .load     ((state_q == DRAIN) && drain_zero),
      .load_val (AW'(AUTO_RESUME_CYCLES - 1)),
      .dec      (state_q == HALTED),
      .zero     (wd_zero)
   );

   assign wd_fire = (state_q == HALTED) && wd_zero;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_q <= 1'b0;
      end else if (state_q == HALTED) begin
         if (bus.Resume_Req) tmo_q <= 1'b0;
         else if (wd_fire)   tmo_q <= 1'b1;
      end
   end

   assign bus.Timeout = tmo_q;
`else
   assign wd_fire     = 1'b0;
   assign bus.Timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= RUN;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (bus.Halt) state_d = DRAIN;
         DRAIN:   if (drain_zero) state_d = HALTED;
         HALTED:  if (bus.Resume_Req || wd_fire) state_d = RESUME;
         RESUME:  state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Target re-latched every HALTED cycle; the value on the exit edge wins
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         first_q <= 1'b0;
         hpc_q   <= '0;
         tgt_q   <= '0;
         hcnt_q  <= '0;
      end else begin
         first_q <= halt_take;
         if (halt_take) begin
            hpc_q <= bus.Halt_PC;
            if (hcnt_q != '1) hcnt_q <= hcnt_q + 1'b1;
         end
         if (state_q == HALTED) begin
            if (bus.Resume_Req && bus.Resume_Use_PC)
               tgt_q <= {bus.Resume_PC[XLEN-1:2], 2'b00};
            else
               tgt_q <= hpc_q + XLEN'(INSN_BYTES);
         end
      end
   end

   assign bus.Stall_Fetch   = (state_q == DRAIN) || (state_q == HALTED);
   assign bus.Flush_Younger = ((state_q == DRAIN) && first_q) ||
                              (state_q == RESUME);
   assign bus.Halted        = (state_q == HALTED);
   assign bus.PC_Load       = (state_q == RESUME);
   assign bus.Resume_Ack    = (state_q == RESUME);
   assign bus.PC_Load_Value = (state_q == RESUME) ? tgt_q : '0;
   assign bus.Halted_PC     = hpc_q;
   assign bus.Halt_Count    = hcnt_q;

endmodule

// File: tb/tb_halt_resume_ctrl.sv
// tb_halt_resume_ctrl: directed vectors for halt_resume_ctrl.
// Define HALT_AUTO_RESUME_EN to also exercise the watchdog.
module tb_halt_resume_ctrl;
   import halt_ctrl_pkg::*;

   logic clk;
   logic reset_n;
   int   vecs;
   int   miss;

   halt_resume_ctrl_if #(.COUNT_W(16)) bus ();

   halt_resume_ctrl #(
      .DRAIN_CYCLES       (3),
      .COUNT_W            (16),
      .AUTO_RESUME_CYCLES (8)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_outs(input string tag, input logic stall,
                           input logic flush, input logic halted,
                           input logic load, input logic [31:0] val);
      chk({tag, ".stall"},  32'(bus.Stall_Fetch),   32'(stall));
      chk({tag, ".flush"},  32'(bus.Flush_Younger), 32'(flush));
      chk({tag, ".halted"}, 32'(bus.Halted),        32'(halted));
      chk({tag, ".load"},   32'(bus.PC_Load),       32'(load));
      chk({tag, ".ack"},    32'(bus.Resume_Ack),    32'(load));
      chk({tag, ".value"},  bus.PC_Load_Value,      val);
   endtask

   initial begin
      vecs = 0;
      miss = 0;
      reset_n = 1'b0;
      bus.Halt = 1'b0;
      bus.Halt_PC = '0;
      bus.Resume_Req = 1'b0;
      bus.Resume_Use_PC = 1'b0;
      bus.Resume_PC = '0;
      #2;
      chk_outs("rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("rst.hpc", bus.Halted_PC, 32'h0);
      chk("rst.cnt", 32'(bus.Halt_Count), 32'h0);
      chk("rst.tmo", 32'(bus.Timeout), 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // Halt at 0x40, resume at PC+4
      bus.Halt = 1'b1;
      bus.Halt_PC = 32'h0000_0040;
      edge1();
      bus.Halt = 1'b0;
      chk_outs("t1.d0", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("t1.hpc", bus.Halted_PC, 32'h40);
      chk("t1.cnt", 32'(bus.Halt_Count), 32'h1);
      edge1();
      chk_outs("t1.d1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      edge1();
      chk_outs("t1.d2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      edge1();
      chk_outs("t1.h0", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      edge1();
      chk_outs("t1.h1", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      bus.Resume_Req = 1'b1;
      edge1();
      bus.Resume_Req = 1'b0;
      chk_outs("t2.rs", 1'b0, 1'b1, 1'b0, 1'b1, 32'h44);
      edge1();
      chk_outs("t2.run", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      // External resume PC with low bits masked
      bus.Halt = 1'b1;
      bus.Halt_PC = 32'h0000_0100;
      edge1();
      bus.Halt = 1'b0;
      repeat (3) edge1();
      chk_outs("t3.h0", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("t3.cnt", 32'(bus.Halt_Count), 32'h2);
      bus.Resume_Req = 1'b1;
      bus.Resume_Use_PC = 1'b1;
      bus.Resume_PC = 32'h0000_1003;
      edge1();
      bus.Resume_Req = 1'b0;
      bus.Resume_Use_PC = 1'b0;
      chk_outs("t3.rs", 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000);
      edge1();

      // Resume_Req held from the Halt cycle; +4 wraps to 0
      bus.Halt = 1'b1;
      bus.Halt_PC = 32'hFFFF_FFFC;
      bus.Resume_Req = 1'b1;
      edge1();
      bus.Halt = 1'b0;
      chk_outs("t4.d0", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      edge1();
      edge1();
      chk_outs("t4.d2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      edge1();
      chk_outs("t4.h0", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      edge1();
      chk_outs("t4.rs", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      chk("t4.cnt", 32'(bus.Halt_Count), 32'h3);
      edge1();
      bus.Resume_Req = 1'b0;
      chk_outs("t4.run", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      // Reset in the second DRAIN cycle
      bus.Halt = 1'b1;
      bus.Halt_PC = 32'h0000_0200;
      edge1();
      bus.Halt = 1'b0;
      edge1();
      chk_outs("t5.d1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      reset_n = 1'b0;
      #1;
      chk_outs("t5.rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("t5.hpc", bus.Halted_PC, 32'h0);
      chk("t5.cnt", 32'(bus.Halt_Count), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         edge1();
         chk_outs("t5.run", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      end

`ifdef HALT_AUTO_RESUME_EN
      // Watchdog resume after 8 HALTED cycles, then a requested resume
      bus.Halt = 1'b1;
      bus.Halt_PC = 32'h0000_0300;
      bus.Resume_Use_PC = 1'b1;
      bus.Resume_PC = 32'h0000_5000;
      edge1();
      bus.Halt = 1'b0;
      repeat (3) edge1();
      for (int i = 0; i < 8; i++) begin
         chk_outs("t6.h", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
         chk("t6.tmo0", 32'(bus.Timeout), 32'h0);
         edge1();
      end
      chk_outs("t6.rs", 1'b0, 1'b1, 1'b0, 1'b1, 32'h304);
      chk("t6.tmo1", 32'(bus.Timeout), 32'h1);
      edge1();
      chk("t6.tmo2", 32'(bus.Timeout), 32'h1);
      bus.Resume_Use_PC = 1'b0;
      bus.Halt = 1'b1;
      bus.Halt_PC = 32'h0000_0400;
      edge1();
      bus.Halt = 1'b0;
      repeat (3) edge1();
      bus.Resume_Req = 1'b1;
      edge1();
      bus.Resume_Req = 1'b0;
      chk_outs("t6.rs2", 1'b0, 1'b1, 1'b0, 1'b1, 32'h404);
      chk("t6.tmo3", 32'(bus.Timeout), 32'h0);
      edge1();
`else
      chk("nowd.tmo", 32'(bus.Timeout), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
